fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
Round-robin, packet-granular arbiter that shares the write port of the async FIFO's write-clock domain among NREQ requesters. It sits entirely in the wclk domain, in front of the FIFO write-pointer/full logic. It drives the FIFO's winc and wdata, and it honours the registered wfull flag. A grant is held for a whole packet, ending with the s_last beat, so packets from different requesters never interleave in the FIFO.

Parameters:
NREQ, 4, number of requesters (2..16)
DSIZE, 8, FIFO data width in bits

Ports:
wclk  input  1  write-domain clock
wrst_n  input  1  asynchronous active-low reset
s_valid  input  NREQ  per-requester beat valid
s_data  input  NREQ*DSIZE  per-requester data; requester i occupies bits [i*DSIZE +: DSIZE]
s_last  input  NREQ  per-requester last beat of packet
s_ready  output  NREQ  per-requester beat accepted when s_valid[i]&s_ready[i]
winc  output  1  FIFO write enable
wdata  output  DSIZE  FIFO write data
wfull  input  1  registered FIFO full flag, wclk domain
grant  output  NREQ  one-hot current owner; all zero when idle
busy  output  1  high while in XFER

Behaviour:
- Clocking/reset: single clock wclk. Asynchronous active-low reset wrst_n. All state uses an async-assert flop on wrst_n.
- Reset values: state=IDLE, grant=0, rr_ptr=0, busy=0, s_ready=0, winc=0, wdata=0. With no grant, wdata is forced to 0, never X.
- IDLE state:
  - If any s_valid is high, select the first requester at or above rr_ptr, wrapping modulo NREQ.
  - Register the one-hot grant and go to XFER.
  - No beat is transferred in the arbitration cycle: 1-cycle arbitration latency.
  - If no s_valid is high, stay in IDLE.
- XFER state, with owner g:
  - s_ready[g] = ~wfull; all other s_ready = 0.
  - winc = s_valid[g] & ~wfull, combinational.
  - wdata = s_data[g].
- End of packet: a beat with s_valid[g] & ~wfull & s_last[g] is written. On the next edge:
  - state goes to IDLE, grant clears;
  - rr_ptr = (g+1) mod NREQ.
- Gap between packets: there is always at least one idle cycle between packets, because re-arbitration happens in IDLE.
- wfull high mid-packet: winc=0, s_ready[g]=0, grant held. The transfer resumes the cycle wfull deasserts. winc is never asserted while wfull=1.
- Owner drops s_valid mid-packet: bubble, no winc, grant held indefinitely. There is no timeout.
- Non-owners asserting s_valid: ignored until the owner's last beat. Their requests are not latched; they are re-evaluated in IDLE.
- Single active requester: re-granted after each packet, with one idle cycle between packets.
- One-beat packet (s_last on first beat): XFER lasts one cycle if ~wfull.
- Reset mid-packet: immediate return to reset values. The partially written packet stays in the FIFO. Packet integrity across reset is the system's responsibility.
- rr_ptr width: clog2(NREQ). Wrap is explicit modulo NREQ, so NREQ need not be a power of two.

Optional Feature:
FIFO_WR_ARB_STATS_EN
- Defined:
  - Adds input stat_clr (1) and output stall_cnt (16).
  - stall_cnt increments each XFER cycle where s_valid[g]&wfull. It saturates at 16'hFFFF.
  - stall_cnt resets to 0 on wrst_n, and clears synchronously on stat_clr. stat_clr has priority over increment.
- Undefined: stat_clr and stall_cnt ports and logic are absent. Core behaviour is identical either way.

Decomposition:
- Package fifo_arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_XFER=1'b1;
  - a clog2 function used to size rr_ptr;
  - the counter width STALL_W=16.
- Sub-module rr_pick: purely combinational.
  - Inputs: req[NREQ], ptr.
  - Outputs: one-hot gnt[NREQ], any.
  - Implements rotate, priority select and un-rotate.
- The top level holds the FSM, the grant/rr_ptr registers, the data mux and the optional counter.

Test Plan:
- Reset, then req0 sends 3 beats (0x11,0x22,0x33 last), wfull=0. Expect: grant=0001 one cycle after s_valid; winc high 3 consecutive cycles; wdata 0x11,0x22,0x33; then grant=0, rr_ptr=1.
- All four requesters send 1-beat packets continuously. Expect: grant order 0,1,2,3,0; one idle cycle between grants; no interleaving.
- req2 packet of 4 beats with wfull forced high on beat 2 for 3 cycles. Expect: winc=0 and s_ready[2]=0 for those 3 cycles; grant stays 0100; 4 total writes; with FIFO_WR_ARB_STATS_EN, stall_cnt=3.
- req1 owner drops s_valid for 2 cycles mid-packet while req3 asserts s_valid. Expect: grant stays 0010; req3 granted only after req1's last beat.
- wrst_n pulsed low mid-packet on beat 2 of 5. Expect: winc, grant, busy and s_ready go 0 asynchronously; after release, arbitration restarts from rr_ptr=0.
- NREQ=3 build, requester 2 finishes a packet. Expect: rr_ptr wraps to 0; next grant is requester 0 when all three are valid.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the async-FIFO write-port arbiter.
//   arb_state_t : FSM encoding (ST_IDLE = arbitrate, ST_XFER = packet in flight)
//   STALL_W     : width of the optional stall counter
//   clog2()     : ceil(log2(n)), floored at 1 so a pointer is never zero-width
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } arb_state_t;

   localparam int STALL_W = 16;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Returns the first requester at or above
// ptr (wrapping modulo NREQ) as a one-hot vector.
//   req [NREQ] : request vector
//   ptr [PW]   : starting index, always < NREQ
//   gnt [NREQ] : one-hot winner, zero when nothing is requested
//   any        : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int PW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic            any
);

   // idx[i] = (ptr + i) mod NREQ; explicit compare-and-subtract so that
   // non-power-of-two NREQ wraps correctly.
   logic [PW-1:0]   idx [NREQ];
   logic [NREQ-1:0] rot;
   logic [NREQ-1:0] sel;

   for (genvar i = 0; i < NREQ; i++) begin : g_idx
      logic [PW:0] sum;
      assign sum    = {1'b0, ptr} + (PW+1)'(i);
      assign idx[i] = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ))
                                             : sum[PW-1:0];
   end

   // Rotate so that position 0 is the current pointer.
   always_comb begin
      rot = '0;
      for (int i = 0; i < NREQ; i++) rot[i] = req[idx[i]];
   end

   // Lowest set bit of the rotated vector is the winner.
   assign sel = rot & (~rot + NREQ'(1));

   // Un-rotate back to requester numbering.
   always_comb begin
      gnt = '0;
      for (int i = 0; i < NREQ; i++) gnt[idx[i]] = gnt[idx[i]] | sel[i];
   end

   assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Packet-granular round-robin arbiter sharing the write port of an async FIFO
// (wclk domain). A grant is held from arbitration until the owner's s_last
// beat is written, so packets never interleave. Arbitration costs one IDLE
// cycle, which also guarantees one idle cycle between packets.
//
// Ports:
//   wclk, wrst_n   : write clock, async active-low reset
//   s_valid[NREQ]  : per-requester beat valid
//   s_data         : requester i at [i*DSIZE +: DSIZE]
//   s_last[NREQ]   : per-requester last beat of packet
//   s_ready[NREQ]  : beat accepted when s_valid[i] & s_ready[i]
//   winc, wdata    : FIFO write enable / data (wdata is 0 with no owner)
//   wfull          : registered FIFO full flag
//   grant[NREQ]    : one-hot current owner, zero when idle
//   busy           : high while a packet is in flight
//
// Build option FIFO_WR_ARB_STATS_EN adds:
//   stat_clr       : synchronous clear of stall_cnt (wins over increment)
//   stall_cnt[16]  : saturating count of cycles the owner was held by wfull
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DSIZE = 8
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic [NREQ-1:0]       s_valid,
   input  logic [NREQ*DSIZE-1:0] s_data,
   input  logic [NREQ-1:0]       s_last,
   output logic [NREQ-1:0]       s_ready,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata,
   input  logic                  wfull,
   output logic [NREQ-1:0]       grant,
   output logic                  busy
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   input  logic                  stat_clr,
   output logic [STALL_W-1:0]    stall_cnt
`endif
);

   localparam int PW = clog2(NREQ);

   arb_state_t      state;
   logic [PW-1:0]   rr_ptr;
   logic [NREQ-1:0] pick;
   logic            pick_any;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   nxt_ptr;
   logic            xfer;
   logic            own_valid;
   logic            own_last;
   logic            beat;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req (s_valid),
      .ptr (rr_ptr),
      .gnt (pick),
      .any (pick_any)
   );

   // Encoded owner index, only meaningful while grant is non-zero.
   always_comb begin
      owner = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) owner = PW'(i);
      end
   end

   assign nxt_ptr = (owner == PW'(NREQ-1)) ? '0 : owner + PW'(1);

   assign xfer      = (state == ST_XFER);
   assign own_valid = |(s_valid & grant);
   assign own_last  = |(s_last & grant);
   assign beat      = xfer & own_valid & ~wfull;

   // Write side is combinational off the registered grant so a beat moves
   // the same cycle wfull drops.
   assign winc    = beat;
   assign s_ready = (xfer && !wfull) ? grant : '0;

   // AND-OR mux keyed by the one-hot grant; yields 0 when idle.
   always_comb begin
      wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         wdata = wdata | (s_data[i*DSIZE +: DSIZE] & {DSIZE{grant[i]}});
      end
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state  <= ST_IDLE;
         grant  <= '0;
         rr_ptr <= '0;
         busy   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // Requests are not latched; whoever is valid now competes.
               if (pick_any) begin
                  grant <= pick;
                  busy  <= 1'b1;
                  state <= ST_XFER;
               end
            end
            ST_XFER: begin
               // Owner keeps the port through bubbles and wfull stalls.
               if (beat && own_last) begin
                  grant  <= '0;
                  busy   <= 1'b0;
                  rr_ptr <= nxt_ptr;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               grant <= '0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic stall;
   assign stall = xfer & own_valid & wfull;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         stall_cnt <= '0;
      end else if (stat_clr) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != {STALL_W{1'b1}})) begin
         stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end
`endif

endmodule
